// File: rtl/led_matrix_scan_ctrl_pkg.sv
// Shared definitions for the 8x8 stacker LED matrix scan controller:
// matrix geometry, scan state encoding and a counter-width helper.
package led_matrix_scan_ctrl_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;
    localparam int ROW_W       = $clog2(MATRIX_ROWS);

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_LOAD  = 2'd1,
        SCAN_BLANK = 2'd2,
        SCAN_SHOW  = 2'd3
    } scan_state_t;

    // Interval counter width: holds values up to max(dwell, blank)-1, never narrower than 1 bit.
    function automatic int cnt_width(input int dwell_cyc, input int blank_cyc);
        int m;
        m = (dwell_cyc > blank_cyc) ? dwell_cyc : blank_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_dwell_timer.sv
// Loadable saturating down-counter with a terminal-count flag. Times both the
// blanking gap and the row dwell; tc_next lets the caller register a pulse that
// coincides with the final cycle of an interval.
module led_matrix_scan_ctrl_dwell_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc,
    output logic             tc_next
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tc      = (count_reg == '0);
    assign tc_next = (count_next == '0);

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-multiplexed scan controller for the 8x8 stacker LED matrix. The engine's
// frame lands in a shadow buffer and is copied to the active buffer only at the
// start of a frame, so the displayed image never tears. Each row is preceded by
// a blanking gap to prevent ghosting. All outputs are registered and aligned
// with the state they describe; polarity is applied only at the output flops.
module led_matrix_scan_ctrl
    import led_matrix_scan_ctrl_pkg::*;
#(
    parameter int DWELL_CYC   = 1024,
    parameter int BLANK_CYC   = 16,
    parameter bit ROW_ACT_LOW = 1'b0,
    parameter bit COL_ACT_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rstBtn,
    input  logic        enable,
    input  logic [63:0] frameIn,
    input  logic        frameWe,
    output logic [7:0]  rowSel,
    output logic [7:0]  colData,
    output logic        frameStart,
    output logic        frameDone
);

    localparam int                CNT_W        = cnt_width(DWELL_CYC, BLANK_CYC);
    localparam logic [CNT_W-1:0]  DWELL_LOAD   = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0]  BLANK_LOAD   = CNT_W'(BLANK_CYC - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW     = ROW_W'(MATRIX_ROWS - 1);
    localparam logic [7:0]        ROW_INACTIVE = {8{ROW_ACT_LOW}};
    localparam logic [7:0]        COL_INACTIVE = {8{COL_ACT_LOW}};

    scan_state_t             state_reg;
    scan_state_t             state_next;
    logic [ROW_W-1:0]        row_reg;
    logic [ROW_W-1:0]        row_next;
    logic [63:0]             shadow_reg;
    logic [63:0]             active_reg;

    logic                    timer_load;
    logic [CNT_W-1:0]        timer_val;
    logic                    timer_tc;
    logic                    timer_tc_next;

    logic [MATRIX_ROWS-1:0]  row_onehot;
    logic                    lit_next;
    logic [7:0]              row_sel_next;
    logic [7:0]              col_data_next;
    logic                    frame_start_next;
    logic                    frame_done_next;

    led_matrix_scan_ctrl_dwell_timer #(
        .WIDTH (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .srst     (rstBtn),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc),
        .tc_next  (timer_tc_next)
    );

    // One-hot decode of the row that will be lit next cycle.
    generate
        for (genvar gi = 0; gi < MATRIX_ROWS; gi++) begin : g_row_decode
            assign row_onehot[gi] = (row_next == ROW_W'(gi));
        end
    endgenerate

    // Next-state logic. The timer is reloaded on every state change (so it never
    // wraps) and only counts down while dwelling in BLANK or SHOW.
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        timer_load = 1'b1;
        timer_val  = '0;
        if (!enable) begin
            state_next = SCAN_IDLE;
            row_next   = '0;
        end else begin
            case (state_reg)
                SCAN_IDLE: begin
                    state_next = SCAN_LOAD;
                end
                SCAN_LOAD: begin
                    state_next = SCAN_BLANK;
                    row_next   = '0;
                    timer_val  = BLANK_LOAD;
                end
                SCAN_BLANK: begin
                    if (timer_tc) begin
                        state_next = SCAN_SHOW;
                        timer_val  = DWELL_LOAD;
                    end else begin
                        timer_load = 1'b0;
                    end
                end
                SCAN_SHOW: begin
                    if (timer_tc) begin
                        if (row_reg == LAST_ROW) begin
                            state_next = SCAN_LOAD;
                            row_next   = '0;
                        end else begin
                            state_next = SCAN_BLANK;
                            row_next   = row_reg + 1'b1;
                            timer_val  = BLANK_LOAD;
                        end
                    end else begin
                        timer_load = 1'b0;
                    end
                end
                default: begin
                    state_next = SCAN_IDLE;
                    row_next   = '0;
                end
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state register.
    always_comb begin
        lit_next         = (state_next == SCAN_SHOW);
        row_sel_next     = lit_next ? row_onehot : 8'h00;
        col_data_next    = lit_next ? active_reg[{row_next, 3'b000} +: 8] : 8'h00;
        frame_start_next = (state_next == SCAN_LOAD);
        frame_done_next  = lit_next && (row_next == LAST_ROW) && timer_tc_next;
    end

    // State, row index and frame buffers. A write in the LOAD cycle goes straight
    // through to the active buffer so it is shown in the frame just starting.
    always_ff @(posedge clk) begin
        if (rstBtn) begin
            state_reg  <= SCAN_IDLE;
            row_reg    <= '0;
            shadow_reg <= '0;
            active_reg <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            if (frameWe) begin
                shadow_reg <= frameIn;
            end
            if (state_reg == SCAN_LOAD) begin
                active_reg <= frameWe ? frameIn : shadow_reg;
            end
        end
    end

    // Output registers; pin polarity is applied only here.
    always_ff @(posedge clk) begin
        if (rstBtn) begin
            rowSel     <= ROW_INACTIVE;
            colData    <= COL_INACTIVE;
            frameStart <= 1'b0;
            frameDone  <= 1'b0;
        end else begin
            rowSel     <= row_sel_next ^ ROW_INACTIVE;
            colData    <= col_data_next ^ COL_INACTIVE;
            frameStart <= frame_start_next;
            frameDone  <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Scoreboard bench for led_matrix_scan_ctrl (DWELL=4, BLANK=2, 49-cycle frame).
// The stimulus process drives one cycle at a time, advances a frame-position
// reference model and queues the expected outputs; a monitor pops and compares
// after every clock edge. A second instance with inverted pin polarity shares
// the same inputs.
module tb_led_matrix_scan_ctrl;

    localparam int D      = 4;
    localparam int B      = 2;
    localparam int ROWP   = B + D;
    localparam int FRAME  = 1 + 8 * ROWP;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        logic       fs;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstBtn = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] frameIn = '0;
    logic        frameWe = 1'b0;

    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_start;
    logic        frame_done;
    logic [7:0]  row_sel_n;
    logic [7:0]  col_data_n;
    logic        frame_start_n;
    logic        frame_done_n;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];

    // Reference model state: running flag, position within frame, buffers.
    bit          m_run = 1'b0;
    int          m_phase = 0;
    logic [63:0] m_shadow = '0;
    logic [63:0] m_active = '0;

    led_matrix_scan_ctrl #(
        .DWELL_CYC   (D),
        .BLANK_CYC   (B),
        .ROW_ACT_LOW (1'b0),
        .COL_ACT_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rstBtn     (rstBtn),
        .enable     (enable),
        .frameIn    (frameIn),
        .frameWe    (frameWe),
        .rowSel     (row_sel),
        .colData    (col_data),
        .frameStart (frame_start),
        .frameDone  (frame_done)
    );

    led_matrix_scan_ctrl #(
        .DWELL_CYC   (D),
        .BLANK_CYC   (B),
        .ROW_ACT_LOW (1'b1),
        .COL_ACT_LOW (1'b1)
    ) dut_inv (
        .clk        (clk),
        .rstBtn     (rstBtn),
        .enable     (enable),
        .frameIn    (frameIn),
        .frameWe    (frameWe),
        .rowSel     (row_sel_n),
        .colData    (col_data_n),
        .frameStart (frame_start_n),
        .frameDone  (frame_done_n)
    );

    always #5 clk = ~clk;

    function automatic int ph_row(input int p);
        return (p - 1) / ROWP;
    endfunction

    function automatic bit ph_lit(input int p);
        return (p > 0) && (((p - 1) % ROWP) >= B);
    endfunction

    // Expected outputs for the model's current position.
    function automatic exp_t model_out();
        exp_t e;
        int   q;
        int   r;
        int   o;
        e = '0;
        if (m_run) begin
            if (m_phase == 0) begin
                e.fs = 1'b1;
            end else begin
                q = m_phase - 1;
                r = q / ROWP;
                o = q % ROWP;
                if (o >= B) begin
                    e.row = 8'(1 << r);
                    e.col = m_active[r*8 +: 8];
                    e.fd  = (r == 7) && (o == ROWP - 1);
                end
            end
        end
        return e;
    endfunction

    // Drive one cycle of inputs, advance the model across the coming edge, queue the expectation.
    task automatic step(input logic r, input logic e, input logic w, input logic [63:0] d);
        @(negedge clk);
        rstBtn  = r;
        enable  = e;
        frameWe = w;
        frameIn = d;
        if (r) begin
            m_run    = 1'b0;
            m_phase  = 0;
            m_shadow = '0;
        end else begin
            if (m_run && m_phase == 0) m_active = w ? d : m_shadow;
            if (w) m_shadow = d;
            if (!e) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run   = 1'b1;
                m_phase = 0;
            end else begin
                m_phase = (m_phase == FRAME - 1) ? 0 : m_phase + 1;
            end
        end
        exp_q.push_back(model_out());
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 64'h0);
    endtask

    // Run enabled until the model shows the given row lit (bounded).
    task automatic wait_row_lit(input int row);
        int guard;
        guard = 0;
        while (!(m_run && ph_lit(m_phase) && ph_row(m_phase) == row) && guard < 200) begin
            step(1'b0, 1'b1, 1'b0, 64'h0);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL wait_row_lit row=%0d: not reached within 200 cycles (phase=%0d)", row, m_phase);
        end
    endtask

    // Run enabled until the model sits in the LOAD cycle (bounded).
    task automatic wait_load();
        int guard;
        guard = 0;
        while (!(m_run && m_phase == 0) && guard < 200) begin
            step(1'b0, 1'b1, 1'b0, 64'h0);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL wait_load: LOAD not reached within 200 cycles (phase=%0d)", m_phase);
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp_v);
        end
    endtask

    // Monitor: compare every clock cycle's registered outputs against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rowSel",       row_sel,              e.row);
                chk("colData",      col_data,             e.col);
                chk("frameStart",   {7'd0, frame_start},  {7'd0, e.fs});
                chk("frameDone",    {7'd0, frame_done},   {7'd0, e.fd});
                chk("rowSel_inv",   row_sel_n,            ~e.row);
                chk("colData_inv",  col_data_n,           ~e.col);
                chk("pulses_inv",   {6'd0, frame_start_n, frame_done_n}, {6'd0, e.fs, e.fd});
                chk("rowSel_onehot", {4'd0, 4'($countones(row_sel))}, (row_sel == 8'h00) ? 8'd0 : 8'd1);
                $display("cyc t=%0t rst=%0b en=%0b we=%0b row=%h col=%h fs=%0b fd=%0b",
                         $time, rstBtn, enable, frameWe, row_sel, col_data, frame_start, frame_done);
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        int guard;
        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 64'h0);
        // Full scan of a diagonal pattern, two frames.
        step(1'b0, 1'b0, 1'b1, 64'h8040201008040201);
        idle_run(2 * FRAME + 2);
        // Tear-free: write all-FF while row 3 is lit.
        wait_row_lit(3);
        step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        idle_run(FRAME + 5);
        // Write-through in the LOAD cycle.
        wait_load();
        step(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_00AA);
        idle_run(20);
        // Enable dropped mid row 5, then restored.
        wait_row_lit(5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 64'h0);
        idle_run(20);
        // Reset mid row 2, then restart: shadow cleared.
        wait_row_lit(2);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        idle_run(FRAME + 5);
        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 {$urandom(), $urandom()});
        end
        // Drain the scoreboard.
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog in case the run stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
